// File: rtl/alu_sequencer_pkg.sv
// Shared constants, FSM state encoding and decode helpers for the ALU sequencer.
package alu_sequencer_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CNT_W      = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    // Immediate shifts reuse imm[11:5] as funct7 and must leave it zero.
    function automatic logic is_shift_f3(input logic [2:0] funct3);
        return (funct3 == F3_SLL) || (funct3 == F3_SRX);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the instruction handshake, register-file ports and ALU ports around the sequencer.
interface alu_sequencer_if
    import alu_sequencer_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
);

    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [REG_ADDR_W-1:0] rd_address_a;
    logic [REG_ADDR_W-1:0] rd_address_b;
    logic [XLEN-1:0]       data_out_a;
    logic [XLEN-1:0]       data_out_b;
    logic [2:0]            alu_opcode;
    logic [XLEN-1:0]       alu_left;
    logic [XLEN-1:0]       alu_right;
    logic [XLEN-1:0]       alu_result;
    logic                  wr_enable;
    logic [REG_ADDR_W-1:0] wr_address;
    logic [XLEN-1:0]       wr_data;
    logic                  retired;
    logic                  illegal;
    logic [CNT_W-1:0]      retire_count;

    modport slave (
        input  instr_valid, instr, data_out_a, data_out_b, alu_result,
        output instr_ready, rd_address_a, rd_address_b, alu_opcode, alu_left, alu_right,
               wr_enable, wr_address, wr_data, retired, illegal, retire_count
    );

    modport master (
        output instr_valid, instr, data_out_a, data_out_b, alu_result,
        input  instr_ready, rd_address_a, rd_address_b, alu_opcode, alu_left, alu_right,
               wr_enable, wr_address, wr_data, retired, illegal, retire_count
    );

endinterface

// File: rtl/alu_sequencer_decoder.sv
// Combinational field extraction and legality check for OP-IMM / OP instruction words.
module alu_sequencer_decoder
    import alu_sequencer_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [31:0]           instr_i,
    output logic [REG_ADDR_W-1:0] rs1_o,
    output logic [REG_ADDR_W-1:0] rs2_o,
    output logic [REG_ADDR_W-1:0] rd_o,
    output logic [2:0]            funct3_o,
    output logic [XLEN-1:0]       imm_sext_o,
    output logic                  is_op_o,
    output logic                  is_op_imm_o,
    output logic                  legal_o
);

    logic [6:0] funct7_s;

    assign rs1_o       = REG_ADDR_W'(instr_i[19:15]);
    assign rs2_o       = REG_ADDR_W'(instr_i[24:20]);
    assign rd_o        = REG_ADDR_W'(instr_i[11:7]);
    assign funct3_o    = instr_i[14:12];
    assign funct7_s    = instr_i[31:25];
    assign imm_sext_o  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign is_op_o     = (instr_i[6:0] == OPC_OP);
    assign is_op_imm_o = (instr_i[6:0] == OPC_OP_IMM);

    // The ALU has no alternate-function bit, so any non-zero funct7 on OP is rejected.
    always_comb begin
        legal_o = 1'b0;
        if (is_op_imm_o) begin
            if (is_shift_f3(funct3_o)) begin
                legal_o = (funct7_s == F7_BASE);
            end else begin
                legal_o = 1'b1;
            end
        end else if (is_op_o) begin
            legal_o = (funct7_s == F7_BASE);
        end else begin
            legal_o = 1'b0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: DECODE -> READ -> EXEC -> WB for OP-IMM / OP, DECODE -> TRAP otherwise.
// Sole writer of the register file; suppresses x0 writes and counts retired instructions.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.slave bus
);

    state_e                state_q;
    state_e                state_d;
    logic [31:0]           instr_q;
    logic                  ready_q;
    logic                  wr_en_q;
    logic                  retired_q;
    logic                  illegal_q;
    logic [XLEN-1:0]       opa_q;
    logic [XLEN-1:0]       opb_q;
    logic [2:0]            alu_op_q;
    logic [XLEN-1:0]       wr_data_q;
    logic [REG_ADDR_W-1:0] wr_addr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [REG_ADDR_W-1:0] rs1_s;
    logic [REG_ADDR_W-1:0] rs2_s;
    logic [REG_ADDR_W-1:0] rd_s;
    logic [2:0]            funct3_s;
    logic [XLEN-1:0]       imm_sext_s;
    logic                  is_op_s;
    logic                  is_op_imm_s;
    logic                  legal_s;
    logic                  accept_s;

    alu_sequencer_decoder #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_decoder (
        .instr_i     (instr_q),
        .rs1_o       (rs1_s),
        .rs2_o       (rs2_s),
        .rd_o        (rd_s),
        .funct3_o    (funct3_s),
        .imm_sext_o  (imm_sext_s),
        .is_op_o     (is_op_s),
        .is_op_imm_o (is_op_imm_s),
        .legal_o     (legal_s)
    );

    // ready_q is high exactly while in IDLE, so it doubles as the accept qualifier.
    assign accept_s = bus.instr_valid && ready_q;

    // Next-state logic for the fixed phase sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DECODE: begin
                if (legal_s) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers: state, handshake ready and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            ready_q   <= 1'b1;
            wr_en_q   <= 1'b0;
            retired_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ready_q   <= (state_d == S_IDLE);
            illegal_q <= (state_q == S_DECODE) && !legal_s;
            retired_q <= (state_q == S_EXEC);
            wr_en_q   <= (state_q == S_EXEC) && (rd_s != '0);
            if (accept_s) begin
                instr_q <= bus.instr;
            end
            if (state_q == S_EXEC) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers: operands feed the ALU from EXEC onward and hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q     <= '0;
            opb_q     <= '0;
            alu_op_q  <= 3'd0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
        end else begin
            if (state_q == S_READ) begin
                opa_q    <= bus.data_out_a;
                alu_op_q <= funct3_s;
                if (is_op_s) begin
                    opb_q <= bus.data_out_b;
                end else if (is_op_imm_s) begin
                    opb_q <= imm_sext_s;
                end
            end
            if (state_q == S_EXEC) begin
                wr_data_q <= bus.alu_result;
                wr_addr_q <= rd_s;
            end
        end
    end

    assign bus.instr_ready  = ready_q;
    assign bus.rd_address_a = rs1_s;
    assign bus.rd_address_b = rs2_s;
    assign bus.alu_opcode   = alu_op_q;
    assign bus.alu_left     = opa_q;
    assign bus.alu_right    = opb_q;
    // A reset arriving during WB must cancel the write in that very cycle.
    assign bus.wr_enable    = wr_en_q && !rst;
    assign bus.wr_address   = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.retired      = retired_q;
    assign bus.illegal      = illegal_q;
    assign bus.retire_count = cnt_q;

endmodule
